// File: rtl/writeback_arbiter_l7.sv
// Writeback arbiter for the L7 execute pipes.
//
// Collects completed X->W messages from p_num_pipes execute pipes (ALU, mul,
// load-store), grants at most one per cycle in round-robin order and parks it
// in a single output register. The buffered message is offered once to commit
// (ROB); in the cycle it transfers, the physical register file is written and
// the wakeup broadcast is taken from the same RF write strobe.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   x_val   [N]              per-pipe message valid
//   x_rdy   [N]              per-pipe accept, at most one bit high
//   x_pc / x_seq_num / x_waddr / x_preg / x_ppreg / x_wdata / x_wen
//                            per-pipe message fields, pipe i in slice i
//   c_val / c_rdy            commit handshake
//   c_pc / c_seq_num / c_waddr / c_preg / c_ppreg / c_wen
//                            buffered message fields toward commit
//   rf_wen / rf_waddr / rf_wdata
//                            physical register file write port

module writeback_arbiter_l7 #(
  parameter int unsigned p_num_pipes      = 3,
  parameter int unsigned p_seq_num_bits   = 5,
  parameter int unsigned p_phys_addr_bits = 6
) (
  input  logic                                    clk,
  input  logic                                    rst,

  // Execute side
  input  logic [p_num_pipes-1:0]                  x_val,
  output logic [p_num_pipes-1:0]                  x_rdy,
  input  logic [p_num_pipes*32-1:0]               x_pc,
  input  logic [p_num_pipes*p_seq_num_bits-1:0]   x_seq_num,
  input  logic [p_num_pipes*5-1:0]                x_waddr,
  input  logic [p_num_pipes*p_phys_addr_bits-1:0] x_preg,
  input  logic [p_num_pipes*p_phys_addr_bits-1:0] x_ppreg,
  input  logic [p_num_pipes*32-1:0]               x_wdata,
  input  logic [p_num_pipes-1:0]                  x_wen,

  // Commit side
  output logic                                    c_val,
  input  logic                                    c_rdy,
  output logic [31:0]                             c_pc,
  output logic [p_seq_num_bits-1:0]               c_seq_num,
  output logic [4:0]                              c_waddr,
  output logic [p_phys_addr_bits-1:0]             c_preg,
  output logic [p_phys_addr_bits-1:0]             c_ppreg,
  output logic                                    c_wen,

  // Physical register file write
  output logic                                    rf_wen,
  output logic [p_phys_addr_bits-1:0]             rf_waddr,
  output logic [31:0]                             rf_wdata
);

  localparam int unsigned N    = p_num_pipes;
  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

  typedef struct packed {
    logic [31:0]                 pc;
    logic [p_seq_num_bits-1:0]   seq_num;
    logic [4:0]                  waddr;
    logic [p_phys_addr_bits-1:0] preg;
    logic [p_phys_addr_bits-1:0] ppreg;
    logic [31:0]                 wdata;
    logic                        wen;
  } wb_msg_t;

  // ---------------------------------------------------------------------------
  // Per-pipe message unpacking
  // ---------------------------------------------------------------------------
  wb_msg_t pipe_msg [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign pipe_msg[i].pc      = x_pc[32*i +: 32];
    assign pipe_msg[i].seq_num = x_seq_num[p_seq_num_bits*i +: p_seq_num_bits];
    assign pipe_msg[i].waddr   = x_waddr[5*i +: 5];
    assign pipe_msg[i].preg    = x_preg[p_phys_addr_bits*i +: p_phys_addr_bits];
    assign pipe_msg[i].ppreg   = x_ppreg[p_phys_addr_bits*i +: p_phys_addr_bits];
    assign pipe_msg[i].wdata   = x_wdata[32*i +: 32];
    assign pipe_msg[i].wen     = x_wen[i];
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic            out_val_q, out_val_d;
  wb_msg_t         out_msg_q, out_msg_d;
  logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;

  // ---------------------------------------------------------------------------
  // Round-robin grant search, starting at rr_ptr_q and wrapping modulo N
  // ---------------------------------------------------------------------------
  logic            grant_found;
  logic [PtrW-1:0] grant_idx;
  logic [PtrW-1:0] cand;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < int'(N); k++) begin
      // Modulo rather than bit-wrap so non-power-of-two pipe counts work.
      cand = PtrW'((int'(rr_ptr_q) + k) % int'(N));
      if (!grant_found && x_val[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transfer control
  // ---------------------------------------------------------------------------
  logic drain;
  logic free;
  logic accept;

  // Outputs to commit are squashed while reset is asserted so a buffered
  // message can never be committed or written in the reset cycle.
  assign drain  = out_val_q & c_rdy & ~rst;
  // The buffer can refill in the same cycle it drains.
  assign free   = ~out_val_q | c_rdy;
  assign accept = grant_found & free & ~rst;

  always_comb begin
    x_rdy = '0;
    if (accept) begin
      x_rdy[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    out_val_d = out_val_q;
    out_msg_d = out_msg_q;
    rr_ptr_d  = rr_ptr_q;
    if (accept) begin
      out_val_d = 1'b1;
      out_msg_d = pipe_msg[grant_idx];
      rr_ptr_d  = (grant_idx == PtrW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end else if (drain) begin
      out_val_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_val_q <= 1'b0;
      rr_ptr_q  <= '0;
    end else begin
      out_val_q <= out_val_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  // Payload needs no reset: it is only observed while out_val_q is set.
  always_ff @(posedge clk) begin
    out_msg_q <= out_msg_d;
  end

  // ---------------------------------------------------------------------------
  // Commit and register-file outputs
  // ---------------------------------------------------------------------------
  assign c_val     = out_val_q & ~rst;
  assign c_pc      = out_msg_q.pc;
  assign c_seq_num = out_msg_q.seq_num;
  assign c_waddr   = out_msg_q.waddr;
  assign c_preg    = out_msg_q.preg;
  assign c_ppreg   = out_msg_q.ppreg;
  assign c_wen     = out_msg_q.wen;

  // Architectural r0 is hardwired; stores carry wen=0. Both still commit.
  assign rf_wen   = drain & out_msg_q.wen & (out_msg_q.waddr != 5'd0);
  assign rf_waddr = out_msg_q.preg;
  assign rf_wdata = out_msg_q.wdata;

  // ---------------------------------------------------------------------------
  // Protocol checks
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_x_rdy_onehot0 : assert property (@(posedge clk) $onehot0(x_rdy));

  a_commit_stable : assert property (@(posedge clk) disable iff (rst)
    (c_val && !c_rdy) |=> (c_val && $stable({c_pc, c_seq_num, c_waddr, c_preg,
                                              c_ppreg, c_wen, rf_wdata})));

  a_no_x_ctrl : assert property (@(posedge clk)
    !rst |-> !$isunknown({c_val, rf_wen}));
`endif

endmodule

// File: tb/tb_writeback_arbiter_l7.sv
module tb_writeback_arbiter_l7;

  localparam int N  = 3;
  localparam int SB = 5;
  localparam int PB = 6;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    x_val = '0;
  logic [N-1:0]    x_rdy;
  logic [N*32-1:0] x_pc = '0;
  logic [N*SB-1:0] x_seq_num = '0;
  logic [N*5-1:0]  x_waddr = '0;
  logic [N*PB-1:0] x_preg = '0;
  logic [N*PB-1:0] x_ppreg = '0;
  logic [N*32-1:0] x_wdata = '0;
  logic [N-1:0]    x_wen = '0;
  logic            c_val;
  logic            c_rdy = 1'b1;
  logic [31:0]     c_pc;
  logic [SB-1:0]   c_seq_num;
  logic [4:0]      c_waddr;
  logic [PB-1:0]   c_preg;
  logic [PB-1:0]   c_ppreg;
  logic            c_wen;
  logic            rf_wen;
  logic [PB-1:0]   rf_waddr;
  logic [31:0]     rf_wdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  writeback_arbiter_l7 #(
    .p_num_pipes      (N),
    .p_seq_num_bits   (SB),
    .p_phys_addr_bits (PB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .x_val     (x_val),
    .x_rdy     (x_rdy),
    .x_pc      (x_pc),
    .x_seq_num (x_seq_num),
    .x_waddr   (x_waddr),
    .x_preg    (x_preg),
    .x_ppreg   (x_ppreg),
    .x_wdata   (x_wdata),
    .x_wen     (x_wen),
    .c_val     (c_val),
    .c_rdy     (c_rdy),
    .c_pc      (c_pc),
    .c_seq_num (c_seq_num),
    .c_waddr   (c_waddr),
    .c_preg    (c_preg),
    .c_ppreg   (c_ppreg),
    .c_wen     (c_wen),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata)
  );

  // Stimulus helper: load one pipe's message fields and valid.
  task automatic set_pipe(input int i, input logic v, input logic [SB-1:0] seq,
                          input logic [4:0] waddr, input logic [PB-1:0] preg,
                          input logic [31:0] wdata, input logic wen);
    x_val[i]               = v;
    x_pc[32*i +: 32]       = 32'h1000 + 32'(seq) * 4;
    x_seq_num[SB*i +: SB]  = seq;
    x_waddr[5*i +: 5]      = waddr;
    x_preg[PB*i +: PB]     = preg;
    x_ppreg[PB*i +: PB]    = preg + 6'd1;
    x_wdata[32*i +: 32]    = wdata;
    x_wen[i]               = wen;
  endtask

  task automatic clear_pipes();
    x_val = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    x_val = '1;
    c_rdy = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      total++; if (x_rdy !== 3'b000) begin bad++; $display("FAIL reset_x_rdy: got %b want 000", x_rdy); end
      total++; if (c_val !== 1'b0) begin bad++; $display("FAIL reset_c_val: got %b want 0", c_val); end
      total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL reset_rf_wen: got %b want 0", rf_wen); end
    end
    @(negedge clk);
    rst = 1'b0;
    clear_pipes();
  endtask

  task automatic test_single();
    set_pipe(0, 1'b1, 5'd3, 5'd5, 6'd9, 32'hDEADBEEF, 1'b1);
    c_rdy = 1'b1;
    #1;
    total++; if (x_rdy !== 3'b001) begin bad++; $display("FAIL single_x_rdy: got %b want 001", x_rdy); end
    @(negedge clk);
    clear_pipes();
    #1;
    total++; if (c_val !== 1'b1) begin bad++; $display("FAIL single_c_val: got %b want 1", c_val); end
    total++; if (c_seq_num !== 5'd3) begin bad++; $display("FAIL single_seq: got %0d want 3", c_seq_num); end
    total++; if (rf_wen !== 1'b1) begin bad++; $display("FAIL single_rf_wen: got %b want 1", rf_wen); end
    total++; if (rf_waddr !== 6'd9) begin bad++; $display("FAIL single_rf_waddr: got %0d want 9", rf_waddr); end
    total++; if (rf_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL single_rf_wdata: got %h want deadbeef", rf_wdata); end
    total++; if (c_ppreg !== 6'd10) begin bad++; $display("FAIL single_ppreg: got %0d want 10", c_ppreg); end
    @(negedge clk); #1;
    total++; if (c_val !== 1'b0) begin bad++; $display("FAIL single_drain: got %b want 0", c_val); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_rdy [3];
    exp_rdy[0] = 3'b001; exp_rdy[1] = 3'b010; exp_rdy[2] = 3'b100;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    c_rdy = 1'b1;
    for (int i = 0; i < N; i++) set_pipe(i, 1'b1, 5'(10 + i), 5'(1 + i), 6'(20 + i), 32'(i), 1'b1);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        @(negedge clk);
      end
      #1;
      if (k > 0) begin
        total++; if (c_val !== 1'b1) begin bad++; $display("FAIL rr_c_val[%0d]: got %b want 1", k, c_val); end
        total++; if (c_seq_num !== 5'(10 + (k - 1) % 3)) begin bad++; $display("FAIL rr_seq[%0d]: got %0d want %0d", k, c_seq_num, 10 + (k - 1) % 3); end
      end
      total++; if (x_rdy !== exp_rdy[k % 3]) begin bad++; $display("FAIL rr_x_rdy[%0d]: got %b want %b", k, x_rdy, exp_rdy[k % 3]); end
    end
    @(negedge clk);
    clear_pipes();
    #1;
    total++; if (c_seq_num !== 5'd12) begin bad++; $display("FAIL rr_last_seq: got %0d want 12", c_seq_num); end
  endtask

  task automatic test_backpressure();
    // rr_ptr is 0 here; load pipe 0 while the previous message drains.
    @(negedge clk);
    set_pipe(0, 1'b1, 5'd20, 5'd6, 6'd30, 32'hA5A5_0020, 1'b1);
    c_rdy = 1'b1;
    @(negedge clk);
    clear_pipes();
    set_pipe(1, 1'b1, 5'd21, 5'd7, 6'd31, 32'hA5A5_0021, 1'b1);
    c_rdy = 1'b0;
    #1;
    total++; if (x_rdy !== 3'b000) begin bad++; $display("FAIL bp_x_rdy_first: got %b want 000", x_rdy); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      total++; if (c_val !== 1'b1 || c_seq_num !== 5'd20 || c_preg !== 6'd30) begin
        bad++; $display("FAIL bp_hold[%0d]: got val=%b seq=%0d preg=%0d want val=1 seq=20 preg=30", c, c_val, c_seq_num, c_preg); end
      total++; if (x_rdy !== 3'b000) begin bad++; $display("FAIL bp_x_rdy[%0d]: got %b want 000", c, x_rdy); end
      total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL bp_rf_wen[%0d]: got %b want 0", c, rf_wen); end
      total++; if (dut.rr_ptr_q !== 2'd1) begin bad++; $display("FAIL bp_rr_ptr[%0d]: got %0d want 1", c, dut.rr_ptr_q); end
    end
    @(negedge clk);
    c_rdy = 1'b1;
    #1;
    total++; if (x_rdy !== 3'b010) begin bad++; $display("FAIL bp_refill_rdy: got %b want 010", x_rdy); end
    total++; if (rf_wen !== 1'b1 || rf_waddr !== 6'd30) begin bad++; $display("FAIL bp_drain_rf: got wen=%b addr=%0d want wen=1 addr=30", rf_wen, rf_waddr); end
    @(negedge clk);
    clear_pipes();
    #1;
    total++; if (c_val !== 1'b1 || c_seq_num !== 5'd21) begin bad++; $display("FAIL bp_refill_msg: got val=%b seq=%0d want val=1 seq=21", c_val, c_seq_num); end
    total++; if (dut.rr_ptr_q !== 2'd2) begin bad++; $display("FAIL bp_rr_after: got %0d want 2", dut.rr_ptr_q); end
    @(negedge clk); #1;
    total++; if (c_val !== 1'b0) begin bad++; $display("FAIL bp_drain_end: got %b want 0", c_val); end
  endtask

  task automatic test_store_zero();
    // rr_ptr is 2: pipe 2 carries a store, then pipe 0 a load to r0.
    set_pipe(2, 1'b1, 5'd5, 5'd4, 6'd40, 32'h0000_5555, 1'b0);
    c_rdy = 1'b1;
    #1;
    total++; if (x_rdy !== 3'b100) begin bad++; $display("FAIL sz_store_rdy: got %b want 100", x_rdy); end
    @(negedge clk);
    clear_pipes();
    set_pipe(0, 1'b1, 5'd6, 5'd0, 6'd41, 32'h0000_6666, 1'b1);
    #1;
    total++; if (c_val !== 1'b1 || c_seq_num !== 5'd5 || c_wen !== 1'b0) begin
      bad++; $display("FAIL sz_store_commit: got val=%b seq=%0d wen=%b want val=1 seq=5 wen=0", c_val, c_seq_num, c_wen); end
    total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL sz_store_rf_wen: got %b want 0", rf_wen); end
    total++; if (x_rdy !== 3'b001) begin bad++; $display("FAIL sz_load_rdy: got %b want 001", x_rdy); end
    @(negedge clk);
    clear_pipes();
    #1;
    total++; if (c_val !== 1'b1 || c_seq_num !== 5'd6 || c_waddr !== 5'd0) begin
      bad++; $display("FAIL sz_r0_commit: got val=%b seq=%0d waddr=%0d want val=1 seq=6 waddr=0", c_val, c_seq_num, c_waddr); end
    total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL sz_r0_rf_wen: got %b want 0", rf_wen); end
    @(negedge clk); #1;
    total++; if (c_val !== 1'b0) begin bad++; $display("FAIL sz_drain: got %b want 0", c_val); end
  endtask

  task automatic test_wrap();
    // rr_ptr is 1: grant pipe 1 to move it to 2.
    set_pipe(1, 1'b1, 5'd7, 5'd2, 6'd50, 32'h0000_7777, 1'b1);
    #1;
    total++; if (x_rdy !== 3'b010) begin bad++; $display("FAIL wrap_setup_rdy: got %b want 010", x_rdy); end
    @(negedge clk);
    set_pipe(0, 1'b1, 5'd8, 5'd3, 6'd51, 32'h0000_8888, 1'b1);
    set_pipe(1, 1'b1, 5'd9, 5'd3, 6'd52, 32'h0000_9999, 1'b1);
    #1;
    total++; if (dut.rr_ptr_q !== 2'd2) begin bad++; $display("FAIL wrap_ptr_before: got %0d want 2", dut.rr_ptr_q); end
    total++; if (x_rdy !== 3'b001) begin bad++; $display("FAIL wrap_grant: got %b want 001", x_rdy); end
    @(negedge clk);
    clear_pipes();
    #1;
    total++; if (c_seq_num !== 5'd8) begin bad++; $display("FAIL wrap_msg: got %0d want 8", c_seq_num); end
    total++; if (dut.rr_ptr_q !== 2'd1) begin bad++; $display("FAIL wrap_ptr_after: got %0d want 1", dut.rr_ptr_q); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    set_pipe(1, 1'b1, 5'd11, 5'd9, 6'd60, 32'hCAFE_0011, 1'b1);
    c_rdy = 1'b1;
    #1;
    total++; if (x_rdy !== 3'b010) begin bad++; $display("FAIL rm_load_rdy: got %b want 010", x_rdy); end
    @(negedge clk);
    clear_pipes();
    c_rdy = 1'b0;
    #1;
    total++; if (c_val !== 1'b1) begin bad++; $display("FAIL rm_full: got %b want 1", c_val); end
    @(negedge clk);
    rst = 1'b1;
    c_rdy = 1'b1;
    for (int i = 0; i < N; i++) set_pipe(i, 1'b1, 5'(24 + i), 5'd1, 6'(61 + i), 32'(i), 1'b1);
    #1;
    total++; if (x_rdy !== 3'b000) begin bad++; $display("FAIL rm_rst_x_rdy: got %b want 000", x_rdy); end
    total++; if (c_val !== 1'b0) begin bad++; $display("FAIL rm_rst_c_val: got %b want 0", c_val); end
    total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL rm_rst_rf_wen: got %b want 0", rf_wen); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (c_val !== 1'b0) begin bad++; $display("FAIL rm_dropped: got %b want 0", c_val); end
    total++; if (x_rdy !== 3'b001) begin bad++; $display("FAIL rm_first_grant: got %b want 001", x_rdy); end
    @(negedge clk);
    clear_pipes();
    #1;
    total++; if (c_val !== 1'b1 || c_seq_num !== 5'd24) begin bad++; $display("FAIL rm_after_msg: got val=%b seq=%0d want val=1 seq=24", c_val, c_seq_num); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_store_zero();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
